sound_serializer: RTL and testbench

Output-side transmitter for the four-channel sound path. It accepts mixed 8-bit samples from the channel mixer over a valid/ready handshake and buffers one sample. Each sample is shifted MSB-first onto a three-wire serial DAC interface: bit clock, data and latch strobe. It is the far end of the mixer's `sound_out` bus, turning the parallel mixed sample into the pin-level stream for the external DAC.

---
 rtl/sound_serializer.sv | 121 ++++++++++++
 tb/tb_sound_serializer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_serializer.sv
// sound_serializer: buffers one mixed sample and shifts it MSB-first onto a bit-clock/data/latch DAC port.
// Build option SOUND_SERIALIZER_OFFSET_BIN_EN inverts the sample MSB on load (two's-complement to offset-binary).
module sound_serializer #(
  parameter int WIDTH  = 8,
  parameter int CLKDIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             dac_sclk,
  output logic             dac_sdata,
  output logic             dac_latch,
  output logic             busy
);
  localparam int DIV_W = (CLKDIV > 1) ? $clog2(2*CLKDIV) : 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*CLKDIV-1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLKDIV);
  localparam logic [DIV_W-1:0] LAT_LAST = DIV_W'(CLKDIV-1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH-1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2} state_t;

  state_t            state, state_next;
  logic [DIV_W-1:0]  div_cnt, div_next;
  logic [BIT_W-1:0]  bit_cnt, bit_next;
  logic [WIDTH-1:0]  shreg, shreg_next;
  logic [WIDTH-1:0]  hold, load_word;
  logic              hold_full, hold_full_next, load, accept;

`ifdef SOUND_SERIALIZER_OFFSET_BIN_EN
  assign load_word = {~hold[WIDTH-1], hold[WIDTH-2:0]};
`else
  assign load_word = hold;
`endif

  assign sample_ready = ~hold_full & ~reset;
  assign accept       = sample_valid & sample_ready;

  // Next-state logic; the divider counter doubles as the latch-pulse timer
  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    shreg_next = shreg;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) load = 1'b1;
        else           load = 1'b0;
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_next   = '0;
          shreg_next = {shreg[WIDTH-2:0], 1'b0};
          if (bit_cnt == BIT_LAST) begin
            bit_next   = '0;
            state_next = LATCH;
          end else begin
            bit_next = bit_cnt + 1'b1;
          end
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end
      LATCH: begin
        if (div_cnt == LAT_LAST) begin
          div_next = '0;
          if (hold_full) load = 1'b1;
          else           state_next = IDLE;
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    if (load) begin
      state_next = SHIFT;
      div_next   = '0;
      bit_next   = '0;
      shreg_next = load_word;
    end
  end

  // hold_full can never set and clear in one cycle: a drain implies ready was low
  always_comb begin
    hold_full_next = hold_full;
    if (load)        hold_full_next = 1'b0;
    else if (accept) hold_full_next = 1'b1;
    else             hold_full_next = hold_full;
  end

  // State, storage and pin registers; pins are decoded from next-state values
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      dac_sclk  <= 1'b0;
      dac_sdata <= 1'b0;
      dac_latch <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      div_cnt   <= div_next;
      bit_cnt   <= bit_next;
      shreg     <= shreg_next;
      hold_full <= hold_full_next;
      if (accept) hold <= sample_in;
      dac_sclk  <= (state_next == SHIFT) && (div_next >= DIV_HALF);
      dac_sdata <= (state_next == SHIFT) && shreg_next[WIDTH-1];
      dac_latch <= (state_next == LATCH);
      busy      <= (state_next != IDLE);
    end
  end
endmodule

// File: tb/tb_sound_serializer.sv
// Self-checking bench for sound_serializer: per-cycle waveform model built from frame start times,
// plus a serial decoder for word-level checks. Follows SOUND_SERIALIZER_OFFSET_BIN_EN like the design.
module tb_sound_serializer;
  localparam int W     = 8;
  localparam int CD    = 4;
  localparam int FRAME = 2*CD*W + CD;
  localparam int NCYC  = 8192;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         sample_ready, dac_sclk, dac_sdata, dac_latch, busy;
  logic [W-1:0] sample_in_1 = '0;
  logic         sample_valid_1 = 1'b0;
  logic         sample_ready_1, dac_sclk_1, dac_sdata_1, dac_latch_1, busy_1;

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  bit e_sclk [NCYC];
  bit e_sdata[NCYC];
  bit e_latch[NCYC];
  bit e_busy [NCYC];
  int last_s = -100000;
  bit accepted;
  logic [W-1:0] dec = '0;
  bit p_sclk, p_latch;
  logic [W-1:0] rx_q[$];
  int lat_q[$];

  sound_serializer #(.WIDTH(W), .CLKDIV(CD)) dut (
    .clk(clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .dac_sclk(dac_sclk), .dac_sdata(dac_sdata),
    .dac_latch(dac_latch), .busy(busy));

  sound_serializer #(.WIDTH(W), .CLKDIV(1)) dut1 (
    .clk(clk), .reset(reset), .sample_in(sample_in_1), .sample_valid(sample_valid_1),
    .sample_ready(sample_ready_1), .dac_sclk(dac_sclk_1), .dac_sdata(dac_sdata_1),
    .dac_latch(dac_latch_1), .busy(busy_1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] xform(input logic [W-1:0] w);
`ifdef SOUND_SERIALIZER_OFFSET_BIN_EN
    return w ^ {1'b1, {(W-1){1'b0}}};
`else
    return w;
`endif
  endfunction

  // Expected pins for a frame whose shift register loads at edge s
  task automatic add_frame(input int s, input logic [W-1:0] w);
    logic [W-1:0] xw;
    xw = xform(w);
    for (int i = 0; i < FRAME; i++) begin
      if (s + i < NCYC) begin
        e_busy[s+i] = 1'b1;
        if (i < 2*CD*W) begin
          e_sclk[s+i]  = ((i % (2*CD)) >= CD);
          e_sdata[s+i] = xw[W-1 - i/(2*CD)];
        end else begin
          e_latch[s+i] = 1'b1;
        end
      end
    end
  endtask

  task automatic clear_from(input int c);
    for (int i = c; i < NCYC; i++) begin
      e_sclk[i] = 1'b0; e_sdata[i] = 1'b0; e_latch[i] = 1'b0; e_busy[i] = 1'b0;
    end
  endtask

  // One clock of the default instance: check ready mid-cycle, update model, check pins after the edge
  task automatic cycle_chk();
    int e, s;
    bit m_ready;
    e = cyc + 1;
    @(negedge clk);
    m_ready = !reset && (e >= last_s + 1);
    checks++;
    if (sample_ready !== m_ready) begin
      errors++;
      $display("FAIL ready cyc %0d got %b exp %b", e, sample_ready, m_ready);
    end
    accepted = sample_valid && m_ready;
    if (accepted) begin
      s = (e + 1 > last_s + FRAME) ? e + 1 : last_s + FRAME;
      add_frame(s, sample_in);
      last_s = s;
    end
    if (reset) begin
      clear_from(e);
      last_s = -100000;
    end
    @(posedge clk); #1;
    checks++;
    if ({dac_sclk, dac_sdata, dac_latch, busy} !== {e_sclk[e], e_sdata[e], e_latch[e], e_busy[e]}) begin
      errors++;
      $display("FAIL pins cyc %0d got sclk/sdata/latch/busy=%b%b%b%b exp %b%b%b%b", e,
               dac_sclk, dac_sdata, dac_latch, busy, e_sclk[e], e_sdata[e], e_latch[e], e_busy[e]);
    end
    if (dac_sclk && !p_sclk) dec = {dec[W-2:0], dac_sdata};
    if (dac_latch && !p_latch) begin
      rx_q.push_back(dec);
      lat_q.push_back(cyc);
    end
    p_sclk = dac_sclk;
    p_latch = dac_latch;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle_chk();
  endtask

  task automatic send(input logic [W-1:0] w, output int acc_cyc);
    bit done;
    done = 1'b0;
    acc_cyc = -1;
    sample_valid = 1'b1;
    sample_in = w;
    for (int i = 0; i < 4*FRAME && !done; i++) begin
      cycle_chk();
      if (accepted) begin
        done = 1'b1;
        acc_cyc = cyc;
      end
    end
    sample_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout sample %h got not-accepted exp accepted", w);
    end
  endtask

  task automatic check_words(input string name, input logic [W-1:0] exp[$]);
    checks++;
    if (rx_q.size() != exp.size()) begin
      errors++;
      $display("FAIL %s_count got %0d exp %0d", name, rx_q.size(), exp.size());
    end else begin
      foreach (exp[i]) begin
        checks++;
        if (rx_q[i] !== exp[i]) begin
          errors++;
          $display("FAIL %s_word%0d got %h exp %h", name, i, rx_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(20);
  endtask

  task automatic test_single();
    int a;
    logic [W-1:0] exp[$];
    rx_q.delete(); lat_q.delete();
    send(8'hA5, a);
    run(FRAME + 4);
    exp.push_back(xform(8'hA5));
    check_words("single", exp);
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2;
    logic [W-1:0] exp[$];
    rx_q.delete(); lat_q.delete();
    send(8'h3C, a0);
    send(8'hC3, a1);
    send(8'hFF, a2);
    run(2*FRAME + 4);
    checks++;
    // hold drains one edge after the first accept, so the next accept lands two edges later
    if (a1 - a0 !== 2) begin errors++; $display("FAIL b2b_accept2 got %0d exp 2", a1 - a0); end
    checks++;
    if (a2 - a0 !== FRAME + 2) begin errors++; $display("FAIL b2b_accept3 got %0d exp %0d", a2 - a0, FRAME + 2); end
    exp.push_back(xform(8'h3C)); exp.push_back(xform(8'hC3)); exp.push_back(xform(8'hFF));
    check_words("b2b", exp);
    if (lat_q.size() == 3) begin
      checks++;
      if (lat_q[1] - lat_q[0] !== FRAME) begin errors++; $display("FAIL b2b_period1 got %0d exp %0d", lat_q[1] - lat_q[0], FRAME); end
      checks++;
      if (lat_q[2] - lat_q[1] !== FRAME) begin errors++; $display("FAIL b2b_period2 got %0d exp %0d", lat_q[2] - lat_q[1], FRAME); end
    end
  endtask

  task automatic test_reset_mid();
    int a;
    logic [W-1:0] exp[$];
    rx_q.delete(); lat_q.delete();
    send(8'hFF, a);
    run(1 + 3*2*CD + 2);
    reset = 1'b1;
    cycle_chk();
    reset = 1'b0;
    run(FRAME + 8);
    check_words("rstmid_nolatch", exp);
    send(8'h81, a);
    run(FRAME + 4);
    exp.push_back(xform(8'h81));
    check_words("rstmid_after", exp);
  endtask

  task automatic test_offset();
    int a;
    logic [W-1:0] exp[$];
    rx_q.delete(); lat_q.delete();
    send(8'h05, a);
    send(8'h80, a);
    run(2*FRAME + 4);
`ifdef SOUND_SERIALIZER_OFFSET_BIN_EN
    exp.push_back(8'h85); exp.push_back(8'h00);
`else
    exp.push_back(8'h05); exp.push_back(8'h80);
`endif
    check_words("offset", exp);
  endtask

  task automatic test_random();
    int a;
    logic [W-1:0] w;
    logic [W-1:0] exp[$];
    rx_q.delete(); lat_q.delete();
    for (int n = 0; n < 12; n++) begin
      run($urandom_range(0, 80));
      w = W'($urandom);
      send(w, a);
      exp.push_back(xform(w));
    end
    run(2*FRAME + 4);
    check_words("random", exp);
  endtask

  task automatic test_clkdiv1();
    int e, i;
    logic [W-1:0] xw;
    bit es, ed, el, eb;
    xw = xform(8'h01);
    sample_valid_1 = 1'b1;
    sample_in_1 = 8'h01;
    e = cyc + 1;
    @(negedge clk);
    checks++;
    if (sample_ready_1 !== 1'b1) begin errors++; $display("FAIL div1_ready got %b exp 1", sample_ready_1); end
    @(posedge clk); #1;
    sample_valid_1 = 1'b0;
    for (int c = e; c < e + 20; c++) begin
      i = c - (e + 1);
      es = (i >= 0 && i < 2*W) && (i % 2 == 1);
      ed = (i >= 0 && i < 2*W) ? xw[W-1 - i/2] : 1'b0;
      el = (i == 2*W);
      eb = (i >= 0 && i <= 2*W);
      checks++;
      if ({dac_sclk_1, dac_sdata_1, dac_latch_1, busy_1} !== {es, ed, el, eb}) begin
        errors++;
        $display("FAIL div1_pins cyc %0d got %b%b%b%b exp %b%b%b%b", c,
                 dac_sclk_1, dac_sdata_1, dac_latch_1, busy_1, es, ed, el, eb);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clear_from(0);
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_offset();
    test_random();
    test_clkdiv1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
